jk_bank_arbiter: RTL
====================

# jk_bank_arbiter

Shares a WIDTH-bit bank of JK flip-flops between N_REQ requesters. Each requester submits a 2-bit JK operation (hold/reset/set/toggle) and a per-bit mask through a valid/ready handshake. A round-robin arbiter grants one request at a time, and a small FSM applies the granted operation to the masked bits in a single clock edge. The block sits between the control logic issuing flag/status updates and the JK register bank it owns.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, JK bank width in bits
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_op  in  2*N_REQ  per-requester op, requester i at [2i+1:2i], encoded {j,k}
- req_mask  in  WIDTH*N_REQ  per-requester bit mask, requester i at [WIDTH*i +: WIDTH]
- req_ready  out  N_REQ  one-hot accept; handshake completes when valid & ready
- q  out  WIDTH  JK bank state
- busy  out  1  high while FSM in APPLY
- done  out  1  one-cycle pulse, cycle after an op is applied
- grant_id  out  clog2(N_REQ)  index of the last/current granted requester

## Operation
- Op encoding {j,k}:
  - 00 HOLD
  - 01 RESET (bit to 0)
  - 10 SET (bit to 1)
  - 11 TOGGLE
- Per bit: if mask bit = 1, the bit gets {j,k} = op; otherwise {j,k} = 00.
- FSM states:
  - IDLE: if any req_valid, choose the winner round-robin starting at rr_ptr. Latch the winner's op, mask and index. Go to APPLY. With no valid, stay in IDLE.
  - APPLY: drive the latched op/mask into the bank. Assert req_ready[winner]. Set rr_ptr = (winner+1) mod N_REQ. Go to IDLE.
- Payload is latched at the IDLE→APPLY edge. Requesters must hold valid/op/mask until ready. If valid drops during APPLY, the latched op is still applied (no cancel).
- Round-robin: rr_ptr resets to 0. Requesters not granted keep waiting; there is no starvation, worst-case wait is N_REQ grants.
- mask = 0 is a legal no-op; the handshake and done still occur.
- Reset (rst = 0 at a clock edge), in any state including mid-APPLY:
  - next state is IDLE; the pending op is discarded and not applied.
  - q = 0, req_ready = 0, busy = 0, done = 0, grant_id = 0, rr_ptr = 0.

## Timing
- Request visible in IDLE at edge t → APPLY during cycle t..t+1, with req_ready and busy high for exactly one cycle.
- q reflects the op after edge t+1. done pulses in the cycle after APPLY, together with the new q.
- Latency: valid sampled → q updated = 2 edges.
- Throughput: one op per 2 cycles. Back-to-back requests alternate IDLE/APPLY.
- req_ready and busy are registered outputs, never combinational from req_valid.
- grant_id updates at the IDLE→APPLY edge and holds until the next grant.
- Simultaneous requests: exactly one grant per APPLY, chosen by rr_ptr priority.

## Structure
- Package jk_ctrl_pkg holds:
  - op constants OP_HOLD = 2'b00, OP_RESET = 2'b01, OP_SET = 2'b10, OP_TOGGLE = 2'b11
  - FSM state encoding ST_IDLE, ST_APPLY
- Sub-module jk_bit_cell: one JK flip-flop bit (clk, rst sync active-low, j, k, q), instantiated WIDTH times via generate.
- Top level contains the round-robin arbiter, latch registers, FSM and the op/mask → j/k fan-out.

## Test plan
All scenarios use N_REQ = 4, WIDTH = 8.
- Reset: rst = 0 for 2 cycles with all req_valid = 1 → q = 8'h00, req_ready = 0, busy = 0, done = 0, grant_id = 0 throughout.
- Single SET: req_valid[0] = 1, op = 10, mask = 8'h0F → req_ready[0] high 1 cycle later for 1 cycle; q = 8'h0F and done = 1 one cycle after that; grant_id = 0.
- Toggle then hold:
  - from q = 8'h0F, req 2 op = 11, mask = 8'hFF → q = 8'hF0, grant_id = 2.
  - then op = 00, mask = 8'hFF → q stays 8'hF0, done still pulses.
- Fairness: all 4 valid continuously from reset → grant_id sequence 0, 1, 2, 3, 0 at 2-cycle spacing; exactly one req_ready bit high per APPLY.
- Reset mid-APPLY: req 1 SET mask 8'hFF, rst = 0 during its APPLY cycle → q = 8'h00 after the edge, no done pulse; after release the next grant starts from requester 0.
- Valid dropped during APPLY: req 3 RESET mask 8'h01 from q = 8'hFF, valid deasserted in APPLY → q = 8'hFE anyway, done pulses.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank arbiter slice.
//   - JK op encodings {j,k}: hold / reset / set / toggle
//   - FSM state encoding for the arbiter/apply controller
//   - jk_next(): next-state function of a single JK flip-flop
package jk_ctrl_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case ({j, k})
      OP_HOLD:   nq = q;
      OP_RESET:  nq = 1'b0;
      OP_SET:    nq = 1'b1;
      OP_TOGGLE: nq = ~q;
      default:   nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bus of the JK bank arbiter.
//   req_valid [N_REQ]        per-requester request valid
//   req_op    [2*N_REQ]      per-requester {j,k} op, requester i at [2i+1:2i]
//   req_mask  [WIDTH*N_REQ]  per-requester bit mask, requester i at [WIDTH*i +: WIDTH]
//   req_ready [N_REQ]        one-hot accept, handshake completes on valid & ready
//   q         [WIDTH]        JK bank state
//   busy                     high while the controller is applying an op
//   done                     one-cycle pulse in the cycle after an op is applied
//   grant_id  [ID_W]         index of the last/current granted requester
// master: requester side, slave: arbiter side.
interface jk_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [2*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_mask;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       q;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        grant_id;

  modport master (
    output req_valid, req_op, req_mask,
    input  req_ready, q, busy, done, grant_id
  );

  modport slave (
    input  req_valid, req_op, req_mask,
    output req_ready, q, busy, done, grant_id
  );

endinterface

// File: rtl/jk_bit_cell.sv
// One JK flip-flop of the bank.
//   clk  rising-edge clock
//   rst  synchronous active-low reset, clears q
//   j,k  JK inputs ({j,k} = 00 hold, 01 reset, 10 set, 11 toggle)
//   q    stored bit
module jk_bit_cell
  import jk_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst) q <= 1'b0;
    else      q <= jk_next(q, j, k);
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a WIDTH-bit JK flip-flop bank among N_REQ
// requesters. A request seen in IDLE is latched (op, mask, index) and
// applied to the masked bits during the following APPLY cycle; one op
// completes every two cycles.
//   clk  rising-edge clock
//   rst  synchronous active-low reset (any state, pending op discarded)
//   bus  jk_bank_arbiter_if.slave: req_valid/req_op/req_mask in,
//        req_ready/q/busy/done/grant_id out
module jk_bank_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  jk_bank_arbiter_if.slave   bus
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic              done_q, done_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;

  logic [WIDTH-1:0]  j_vec, k_vec, q_vec;
  logic              apply;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(N_REQ - 1)) return '0;
    else                        return id + 1'b1;
  endfunction

  // Round-robin search: first valid requester at or after rr_q, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = rr_q;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Next-state / output logic. req_ready and done are produced here and
  // registered below, so they never depend combinationally on req_valid.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    ready_d = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_APPLY;
          op_d    = bus.req_op[2*win_id +: 2];
          mask_d  = bus.req_mask[WIDTH*win_id +: WIDTH];
          grant_d = win_id;
          for (int i = 0; i < N_REQ; i++) ready_d[i] = (ID_W'(i) == win_id);
        end
      end
      ST_APPLY: begin
        // The latched op is applied at the end of this cycle regardless of
        // what the requester does with valid meanwhile.
        state_d = ST_IDLE;
        done_d  = 1'b1;
        rr_d    = next_id(grant_q);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      ready_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Payload latch: only consumed in APPLY, which reset always leaves.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    mask_q <= mask_d;
  end

  // Op/mask fan-out: unmasked bits (and every bit outside APPLY) hold.
  assign apply = (state_q == ST_APPLY);
  assign j_vec = {WIDTH{apply & op_q[1]}} & mask_q;
  assign k_vec = {WIDTH{apply & op_q[0]}} & mask_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_bit_cell u_bit (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[b]),
      .k   (k_vec[b]),
      .q   (q_vec[b])
    );
  end

  assign bus.req_ready = ready_q;
  assign bus.q         = q_vec;
  assign bus.busy      = apply;
  assign bus.done      = done_q;
  assign bus.grant_id  = grant_q;

endmodule
